// File: rtl/router_reg.sv
`default_nettype none
// ============================================================================
//  Module      : router_reg
//  Description : Router packet datapath register. Latches the header byte,
//                steers header/payload/parity bytes onto the FIFO write bus,
//                parks one byte while the selected FIFO is full, accumulates
//                XOR parity over header and payload, captures the packet
//                parity byte and flags a mismatch.
//  Revision    : 1.0 - initial release
// ============================================================================
module router_reg #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_BITS  = 2
) (
    input  logic                  clock,
    input  logic                  resetn,
    input  logic                  pkt_valid,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  fifo_full,
    input  logic                  detect_add,
    input  logic                  ld_state,
    input  logic                  laf_state,
    input  logic                  full_state,
    input  logic                  lfd_state,
    input  logic                  rst_int_reg,
    output logic                  parity_done,
    output logic                  low_pkt_valid,
    output logic                  err,
    output logic [DATA_WIDTH-1:0] dout
);

    // Destination value that no FIFO exists for; such headers are ignored.
    localparam logic [ADDR_BITS-1:0] C_BAD_ADDR = {ADDR_BITS{1'b1}};

    logic [DATA_WIDTH-1:0] dout_q,            dout_d;
    logic [DATA_WIDTH-1:0] header_byte_q,     header_byte_d;
    logic [DATA_WIDTH-1:0] full_byte_q,       full_byte_d;
    logic [DATA_WIDTH-1:0] internal_parity_q, internal_parity_d;
    logic [DATA_WIDTH-1:0] packet_parity_q,   packet_parity_d;
    logic                  parity_done_q,     parity_done_d;
    logic                  low_pkt_valid_q,   low_pkt_valid_d;
    logic                  err_q,             err_d;

    // Next-state for every datapath register; each update evaluates independently.
    always_comb begin
        dout_d            = dout_q;
        header_byte_d     = header_byte_q;
        full_byte_d       = full_byte_q;
        internal_parity_d = internal_parity_q;
        packet_parity_d   = packet_parity_q;
        parity_done_d     = parity_done_q;
        low_pkt_valid_d   = low_pkt_valid_q;
        err_d             = err_q;

        // Header latch, skipping the unroutable address.
        if (detect_add && pkt_valid && (data_in[ADDR_BITS-1:0] != C_BAD_ADDR))
            header_byte_d = data_in;

        // FIFO write bus: header first, then live data, then the parked byte.
        if (lfd_state)
            dout_d = header_byte_q;
        else if (ld_state && !fifo_full)
            dout_d = data_in;
        else if (laf_state)
            dout_d = full_byte_q;

        // Park the byte that arrived while the FIFO was full.
        if (ld_state && fifo_full)
            full_byte_d = data_in;

        // Running parity over header and payload; the parity byte is excluded.
        if (detect_add)
            internal_parity_d = '0;
        if (lfd_state)
            internal_parity_d = internal_parity_d ^ header_byte_q;
        if (ld_state && pkt_valid && !full_state)
            internal_parity_d = internal_parity_d ^ data_in;

        // End-of-payload flag; a new set in the same cycle beats the clear.
        if (rst_int_reg)
            low_pkt_valid_d = 1'b0;
        if (ld_state && !pkt_valid)
            low_pkt_valid_d = 1'b1;

        // Parity byte capture, either directly or from the parked byte.
        if (detect_add) begin
            packet_parity_d = '0;
            parity_done_d   = 1'b0;
        end
        if (ld_state && !pkt_valid && !fifo_full) begin
            packet_parity_d = data_in;
            parity_done_d   = 1'b1;
        end
        if (laf_state && low_pkt_valid_q && !parity_done_q) begin
            packet_parity_d = full_byte_q;
            parity_done_d   = 1'b1;
        end

        // Compare once the parity byte is in; a new packet clears the flag.
        if (parity_done_q)
            err_d = (internal_parity_q != packet_parity_q);
        if (detect_add)
            err_d = 1'b0;
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            dout_q            <= '0;
            header_byte_q     <= '0;
            full_byte_q       <= '0;
            internal_parity_q <= '0;
            packet_parity_q   <= '0;
            parity_done_q     <= 1'b0;
            low_pkt_valid_q   <= 1'b0;
            err_q             <= 1'b0;
        end else begin
            dout_q            <= dout_d;
            header_byte_q     <= header_byte_d;
            full_byte_q       <= full_byte_d;
            internal_parity_q <= internal_parity_d;
            packet_parity_q   <= packet_parity_d;
            parity_done_q     <= parity_done_d;
            low_pkt_valid_q   <= low_pkt_valid_d;
            err_q             <= err_d;
        end
    end

    assign dout          = dout_q;
    assign parity_done   = parity_done_q;
    assign low_pkt_valid = low_pkt_valid_q;
    assign err           = err_q;

endmodule
`default_nettype wire

// File: tb/tb_router_reg.sv
`default_nettype none
// ============================================================================
//  Module      : tb_router_reg
//  Description : Randomized self-checking bench for router_reg. Acts as the
//                router FSM, and predicts the FIFO byte stream and parity
//                verdict per packet from the packet contents.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_router_reg;

    logic       clock;
    logic       resetn;
    logic       pkt_valid;
    logic [7:0] data_in;
    logic       fifo_full;
    logic       detect_add;
    logic       ld_state;
    logic       laf_state;
    logic       full_state;
    logic       lfd_state;
    logic       rst_int_reg;
    logic       parity_done;
    logic       low_pkt_valid;
    logic       err;
    logic [7:0] dout;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference state: the header the DUT should hold and the last bus byte.
    logic [7:0] exp_hdr;
    logic [7:0] exp_dout;

    logic [7:0] pay [0:15];
    int         pay_len;

    router_reg #(.DATA_WIDTH(8), .ADDR_BITS(2)) dut (
        .clock         (clock),
        .resetn        (resetn),
        .pkt_valid     (pkt_valid),
        .data_in       (data_in),
        .fifo_full     (fifo_full),
        .detect_add    (detect_add),
        .ld_state      (ld_state),
        .laf_state     (laf_state),
        .full_state    (full_state),
        .lfd_state     (lfd_state),
        .rst_int_reg   (rst_int_reg),
        .parity_done   (parity_done),
        .low_pkt_valid (low_pkt_valid),
        .err           (err),
        .dout          (dout)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_tests++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_strobes();
        detect_add  = 1'b0;
        ld_state    = 1'b0;
        laf_state   = 1'b0;
        full_state  = 1'b0;
        lfd_state   = 1'b0;
        rst_int_reg = 1'b0;
        fifo_full   = 1'b0;
    endtask

    // FIFO_FULL_STATE followed by LOAD_AFTER_FULL.
    task automatic drain_full();
        clear_strobes();
        full_state = 1'b1;
        fifo_full  = 1'b1;
        pkt_valid  = 1'($urandom);
        data_in    = 8'($urandom);
        step();
        check_eq("full_hold_dout", int'(dout), int'(exp_dout));
        clear_strobes();
        laf_state = 1'b1;
        data_in   = 8'($urandom);
        step();
    endtask

    // Drives one whole packet through the strobe sequence and checks it.
    task automatic send_packet(input logic [7:0] hdr, input logic [7:0] par,
                               input int stall_idx, input bit stall_par);
        logic [7:0] ref_par;
        clear_strobes();
        detect_add = 1'b1;
        pkt_valid  = 1'b1;
        data_in    = hdr;
        step();
        check_eq("det_parity_done", int'(parity_done), 0);
        check_eq("det_err", int'(err), 0);
        if (hdr[1:0] != 2'b11) exp_hdr = hdr;

        clear_strobes();
        lfd_state = 1'b1;
        data_in   = 8'($urandom);
        step();
        exp_dout = exp_hdr;
        check_eq("lfd_dout", int'(dout), int'(exp_dout));
        ref_par = exp_hdr;

        for (int i = 0; i < pay_len; i++) begin
            clear_strobes();
            ld_state  = 1'b1;
            pkt_valid = 1'b1;
            data_in   = pay[i];
            fifo_full = (i == stall_idx);
            step();
            ref_par ^= pay[i];
            if (i == stall_idx) begin
                check_eq("stall_dout", int'(dout), int'(exp_dout));
                drain_full();
                exp_dout = pay[i];
                check_eq("laf_dout", int'(dout), int'(exp_dout));
            end else begin
                exp_dout = pay[i];
                check_eq("ld_dout", int'(dout), int'(exp_dout));
            end
        end

        clear_strobes();
        ld_state  = 1'b1;
        pkt_valid = 1'b0;
        data_in   = par;
        fifo_full = stall_par;
        step();
        check_eq("low_pkt_valid_set", int'(low_pkt_valid), 1);
        if (stall_par) begin
            check_eq("par_stall_dout", int'(dout), int'(exp_dout));
            check_eq("par_stall_done", int'(parity_done), 0);
            drain_full();
        end
        exp_dout = par;
        check_eq("par_dout", int'(dout), int'(exp_dout));
        check_eq("par_done", int'(parity_done), 1);

        clear_strobes();
        data_in = 8'($urandom);
        step();
        check_eq("err", int'(err), int'(ref_par != par));

        clear_strobes();
        rst_int_reg = 1'b1;
        step();
        check_eq("low_pkt_valid_clr", int'(low_pkt_valid), 0);
        check_eq("err_hold", int'(err), int'(ref_par != par));
        clear_strobes();
    endtask

    task automatic load_directed(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
        pay[0]  = a;
        pay[1]  = b;
        pay[2]  = c;
        pay_len = 3;
    endtask

    task automatic check_reset_state(input string tag);
        check_eq({tag, "_dout"}, int'(dout), 0);
        check_eq({tag, "_err"}, int'(err), 0);
        check_eq({tag, "_parity_done"}, int'(parity_done), 0);
        check_eq({tag, "_low_pkt_valid"}, int'(low_pkt_valid), 0);
    endtask

    initial begin
        logic [7:0] hdr;
        logic [7:0] par;
        int         stall_idx;
        bit         stall_par;

        clear_strobes();
        pkt_valid = 1'b0;
        data_in   = 8'h00;
        resetn    = 1'b0;
        exp_hdr   = 8'h00;
        exp_dout  = 8'h00;
        step();
        step();
        check_reset_state("por");
        resetn = 1'b1;

        // Good packet, no stall.
        load_directed(8'h11, 8'h22, 8'h33);
        send_packet(8'h0D, 8'h0D, -1, 1'b0);
        // Bad parity.
        send_packet(8'h0D, 8'h0E, -1, 1'b0);
        // FIFO full on the middle payload byte.
        send_packet(8'h0D, 8'h0D, 1, 1'b0);
        // FIFO full on the parity byte.
        send_packet(8'h0D, 8'h0D, -1, 1'b1);

        // Unroutable address leaves the header register untouched.
        clear_strobes();
        detect_add = 1'b1;
        pkt_valid  = 1'b1;
        data_in    = 8'h0F;
        step();
        clear_strobes();
        lfd_state = 1'b1;
        step();
        check_eq("bad_addr_hdr", int'(dout), 8'h0D);
        exp_dout = 8'h0D;

        // Reset in the middle of a packet, with strobes still active.
        load_directed(8'hA5, 8'h5A, 8'hC3);
        send_packet(8'h0E, 8'h00, -1, 1'b0);
        clear_strobes();
        detect_add = 1'b1;
        pkt_valid  = 1'b1;
        data_in    = 8'h09;
        step();
        clear_strobes();
        resetn    = 1'b0;
        ld_state  = 1'b1;
        pkt_valid = 1'b0;
        data_in   = 8'hFF;
        step();
        step();
        check_reset_state("mid_rst");
        resetn   = 1'b1;
        exp_hdr  = 8'h00;
        exp_dout = 8'h00;
        clear_strobes();

        // Random packets.
        for (int p = 0; p < 60; p++) begin
            pay_len = $urandom_range(0, 6);
            hdr     = {6'(pay_len), 2'($urandom_range(0, 2))};
            par     = hdr;
            for (int i = 0; i < pay_len; i++) begin
                pay[i] = 8'($urandom);
                par ^= pay[i];
            end
            if ($urandom_range(0, 1) == 1) par = 8'($urandom);
            stall_idx = ($urandom_range(0, 2) == 0 && pay_len > 0) ? $urandom_range(0, pay_len - 1) : -1;
            stall_par = ($urandom_range(0, 3) == 0);
            send_packet(hdr, par, stall_idx, stall_par);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
